// File: rtl/dispatch_4way_if.sv
// Handshake bundle for the 4-way dispatcher: one upstream producer port,
// four one-hot downstream lanes sharing a broadcast data bus.
interface dispatch_4way_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic [1:0]       in_dest_i;
  logic             mode_rr_i;
  logic [3:0]       out_valid_o;
  logic [3:0]       out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic             busy_o;
  logic             drop_o;
  logic [1:0]       rr_ptr_o;

  modport master (
    output in_valid_i, in_data_i, in_dest_i, mode_rr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, busy_o, drop_o, rr_ptr_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_dest_i, mode_rr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, busy_o, drop_o, rr_ptr_o
  );
endinterface

// File: rtl/dispatch_4way.sv
// Routes each accepted word to one of four lanes (addressed or round-robin),
// holding it in a single register until the lane accepts or a stall timeout drops it.
module dispatch_4way #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0
) (
  input logic            clk_i,
  input logic            rst_n_i,
  dispatch_4way_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  state_t           state_r;
  logic [1:0]       tgt_r;
  logic [1:0]       rr_ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [3:0]       valid_r;
  logic             busy_r;
  logic             drop_r;
  logic [CW-1:0]    stall_cnt_r;

  logic             done_s;
  logic             timeout_s;
  logic             ready_s;
  logic             accept_s;
  logic [1:0]       next_tgt_s;

  // A completing transfer frees the register in the same cycle, giving 1 word/cycle.
  always_comb begin
    done_s     = (state_r == HOLD) && bus.out_ready_i[tgt_r];
    timeout_s  = (TIMEOUT > 0) && (state_r == HOLD) && !done_s && (stall_cnt_r == CNT_LAST);
    ready_s    = (state_r == IDLE) || done_s;
    accept_s   = bus.in_valid_i && ready_s;
    next_tgt_s = bus.mode_rr_i ? rr_ptr_r : bus.in_dest_i;
  end

  assign bus.in_ready_o  = ready_s;
  assign bus.out_valid_o = valid_r;
  assign bus.out_data_o  = data_r;
  assign bus.busy_o      = busy_r;
  assign bus.drop_o      = drop_r;
  assign bus.rr_ptr_o    = rr_ptr_r;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= IDLE;
      tgt_r       <= 2'd0;
      rr_ptr_r    <= 2'd0;
      data_r      <= {WIDTH{1'b0}};
      valid_r     <= 4'b0000;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
      stall_cnt_r <= {CW{1'b0}};
    end else begin
      drop_r <= 1'b0;
      if (accept_s && bus.mode_rr_i) begin
        rr_ptr_r <= rr_ptr_r + 2'd1;
      end
      if (accept_s) begin
        state_r     <= HOLD;
        tgt_r       <= next_tgt_s;
        data_r      <= bus.in_data_i;
        valid_r     <= onehot4(next_tgt_s);
        busy_r      <= 1'b1;
        stall_cnt_r <= {CW{1'b0}};
      end else if (done_s || timeout_s) begin
        state_r <= IDLE;
        valid_r <= 4'b0000;
        busy_r  <= 1'b0;
        drop_r  <= timeout_s;
      end else if ((state_r == HOLD) && (TIMEOUT > 0)) begin
        // Drop fires at CNT_LAST, so the counter can never pass it.
        stall_cnt_r <= stall_cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_4way.sv
// Drives a TIMEOUT=0 and a TIMEOUT=4 dispatcher with identical stimulus and
// compares both against a held-word reference model every cycle.
module tb_dispatch_4way;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             mode_rr;
  logic [3:0]       out_ready;

  dispatch_4way_if #(.WIDTH(WIDTH)) bus0 ();
  dispatch_4way_if #(.WIDTH(WIDTH)) bus4 ();

  assign bus0.in_valid_i  = in_valid;
  assign bus0.in_data_i   = in_data;
  assign bus0.in_dest_i   = in_dest;
  assign bus0.mode_rr_i   = mode_rr;
  assign bus0.out_ready_i = out_ready;
  assign bus4.in_valid_i  = in_valid;
  assign bus4.in_data_i   = in_data;
  assign bus4.in_dest_i   = in_dest;
  assign bus4.mode_rr_i   = mode_rr;
  assign bus4.out_ready_i = out_ready;

  dispatch_4way #(.WIDTH(WIDTH), .TIMEOUT(0)) u_dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0.slave));
  dispatch_4way #(.WIDTH(WIDTH), .TIMEOUT(4)) u_dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4.slave));

  // Reference model: is a word held, which lane, how many cycles it has waited.
  bit               m_hold [2];
  logic [WIDTH-1:0] m_data [2];
  int               m_lane [2];
  int               m_rr   [2];
  bit               m_drop [2];
  int               m_age  [2];
  int               m_to   [2] = '{0, 4};

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int k);
    return !m_hold[k] || out_ready[m_lane[k]];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 1'b0; m_data[k] = '0; m_lane[k] = 0;
      m_rr[k] = 0; m_drop[k] = 1'b0; m_age[k] = 0;
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 2; k++) begin
      bit rdy, done, acc;
      rdy  = exp_ready(k);
      done = m_hold[k] && out_ready[m_lane[k]];
      acc  = in_valid && rdy;
      if (!rst_n) begin
        m_hold[k] = 1'b0; m_data[k] = '0; m_lane[k] = 0;
        m_rr[k] = 0; m_drop[k] = 1'b0; m_age[k] = 0;
      end else begin
        m_drop[k] = 1'b0;
        if (acc) begin
          m_data[k] = in_data;
          m_lane[k] = mode_rr ? m_rr[k] : int'(in_dest);
          if (mode_rr) m_rr[k] = (m_rr[k] + 1) % 4;
          m_hold[k] = 1'b1;
          m_age[k]  = 0;
        end else if (done) begin
          m_hold[k] = 1'b0;
        end else if (m_hold[k]) begin
          m_age[k]++;
          if (m_to[k] > 0 && m_age[k] == m_to[k]) begin
            m_hold[k] = 1'b0;
            m_drop[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_one(input int k, input logic [3:0] v, input logic [WIDTH-1:0] d,
                           input logic b, input logic dr, input logic [1:0] rr);
    logic [3:0] ev;
    ev = m_hold[k] ? (4'b0001 << m_lane[k]) : 4'b0000;
    check($sformatf("t%0d_valid", m_to[k]), 32'(v), 32'(ev));
    check($sformatf("t%0d_data", m_to[k]), 32'(d), 32'(m_data[k]));
    check($sformatf("t%0d_busy", m_to[k]), 32'(b), 32'(m_hold[k]));
    check($sformatf("t%0d_drop", m_to[k]), 32'(dr), 32'(m_drop[k]));
    check($sformatf("t%0d_rr", m_to[k]), 32'(rr), 32'(m_rr[k]));
  endtask

  task automatic check_regs();
    check_one(0, bus0.out_valid_o, bus0.out_data_o, bus0.busy_o, bus0.drop_o, bus0.rr_ptr_o);
    check_one(1, bus4.out_valid_o, bus4.out_data_o, bus4.busy_o, bus4.drop_o, bus4.rr_ptr_o);
  endtask

  task automatic check_ready();
    check("t0_in_ready", 32'(bus0.in_ready_o), 32'(exp_ready(0)));
    check("t4_in_ready", 32'(bus4.in_ready_o), 32'(exp_ready(1)));
  endtask

  task automatic tick();
    @(negedge clk);
    check_ready();
    step_model();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int n_valid, n_drop;
  logic [1:0] rr_before;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = 2'd0;
    mode_rr = 1'b0; out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_regs();
    check_ready();
    rst_n = 1'b1;

    // Addressed word to lane c.
    in_valid = 1'b1; in_dest = 2'd2; in_data = 16'hBEEF; out_ready = 4'b0100;
    tick();
    check("addr_valid", 32'(bus0.out_valid_o), 32'h4);
    check("addr_data", 32'(bus0.out_data_o), 32'hBEEF);
    in_valid = 1'b0;
    tick();
    check("addr_idle", 32'(bus0.busy_o), 32'h0);

    // Round-robin streaming, all lanes ready.
    do_reset();
    mode_rr = 1'b1; out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h1000 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("rr_end_ptr", 32'(bus0.rr_ptr_o), 32'h2);

    // Backpressure on lane b (t4 instance times out during the stall).
    mode_rr = 1'b0; in_valid = 1'b1; in_dest = 2'd1; in_data = 16'hA5A5; out_ready = 4'b1101;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("bp_held", 32'(bus0.out_valid_o), 32'h2);
    out_ready = 4'b0010;
    tick();

    // Timeout: lane d never ready.
    rr_before = bus4.rr_ptr_o;
    in_valid = 1'b1; in_dest = 2'd3; in_data = 16'h5A5A; out_ready = 4'b0111;
    tick();
    in_valid = 1'b0;
    n_valid = (bus4.out_valid_o == 4'b1000) ? 1 : 0;
    n_drop  = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus4.out_valid_o == 4'b1000) n_valid++;
      if (bus4.drop_o) n_drop++;
    end
    check("to_valid_cycles", 32'(n_valid), 32'd4);
    check("to_drop_pulses", 32'(n_drop), 32'd1);
    check("to_rr_kept", 32'(bus4.rr_ptr_o), 32'(rr_before));
    out_ready = 4'b1000;
    tick();
    in_valid = 1'b1; in_dest = 2'd0; in_data = 16'h0F0F; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();

    // Mode mix: rr, addressed to d, rr.
    do_reset();
    out_ready = 4'b1111; in_valid = 1'b1;
    mode_rr = 1'b1; in_data = 16'h0001; tick();
    check("mix_lane_a", 32'(bus0.out_valid_o), 32'h1);
    mode_rr = 1'b0; in_dest = 2'd3; in_data = 16'h0002; tick();
    check("mix_lane_d", 32'(bus0.out_valid_o), 32'h8);
    mode_rr = 1'b1; in_data = 16'h0003; tick();
    check("mix_lane_b", 32'(bus0.out_valid_o), 32'h2);
    in_valid = 1'b0; tick();
    check("mix_rr_ptr", 32'(bus0.rr_ptr_o), 32'h2);

    // Reset during a stalled hold.
    mode_rr = 1'b0; in_valid = 1'b1; in_dest = 2'd2; out_ready = 4'b0000; tick();
    in_valid = 1'b0; tick();
    do_reset();
    check("midrst_ready", 32'(bus0.in_ready_o), 32'h1);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_dest   = 2'($urandom_range(0, 3));
      mode_rr   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dispatch_4way.md
Name: dispatch_4way

Overview:
- Sequencing controller for the 4-way demultiplexed datapath.
- Accepts one word per valid/ready handshake from a single upstream producer and routes it to exactly one of four downstream consumers.
- Destination comes from the word's address (addressed mode) or from an internal round-robin pointer (spread mode).
- Holds the word in a single output register until the selected lane accepts it, or until a stall timeout drops it.

Parameters:
- WIDTH, 16, data word width in bits.
- TIMEOUT, 0, stall cycles before a held word is dropped; 0 disables the timeout (wait forever).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  upstream word valid.
- in_ready_o  out  1  block can accept a word this cycle.
- in_data_i  in  WIDTH  upstream word.
- in_dest_i  in  2  destination lane in addressed mode (0=a, 1=b, 2=c, 3=d).
- mode_rr_i  in  1  0 = addressed, 1 = round-robin.
- out_valid_o  out  4  one-hot lane valid; bit0=a … bit3=d.
- out_ready_i  in  4  per-lane consumer ready.
- out_data_o  out  WIDTH  held word, broadcast to all lanes; meaningful only on the lane whose valid is high.
- busy_o  out  1  a word is held.
- drop_o  out  1  one-cycle pulse when a held word is dropped by timeout.
- rr_ptr_o  out  2  current round-robin pointer.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - State IDLE; out_valid_o=0, out_data_o=0, busy_o=0, drop_o=0, rr_ptr_o=0, stall counter=0.
  - in_ready_o=1 from the first cycle after reset.
  - A word in flight is discarded silently; drop_o is not pulsed.
- States: IDLE, HOLD.
- Registered destination tgt is valid in HOLD. "done" means out_ready_i[tgt]=1 while in HOLD.
- in_ready_o is combinational: 1 in IDLE, or in HOLD when done is true. It is 0 on a timeout-drop cycle.
- Accept: in_valid_i & in_ready_o at a clock edge.
  - Latch in_data_i into out_data_o.
  - Set tgt = mode_rr_i ? rr_ptr : in_dest_i. mode_rr_i is sampled only at accept.
  - Next cycle: state HOLD, out_valid_o = one-hot(tgt), busy_o=1, stall counter=0.
  - Latency: word visible on its lane exactly 1 cycle after accept.
- Round-robin pointer:
  - Increments mod 4 on every accept made in round-robin mode (3 wraps to 0).
  - Unchanged by addressed-mode accepts and by drops.
- HOLD with done true:
  - The transfer completes at that edge.
  - If an accept occurs on the same edge, stay in HOLD with the new word and tgt; otherwise go to IDLE and clear out_valid_o.
  - Back-to-back throughput is 1 word/cycle.
- HOLD with done false:
  - out_valid_o and out_data_o stay stable.
  - Ready on non-target lanes is ignored.
- Timeout (TIMEOUT>0):
  - Stall counter increments on each HOLD edge where done is false.
  - On an edge where done is false and counter == TIMEOUT-1:
    - The word is dropped.
    - Next cycle: IDLE, out_valid_o=0, drop_o=1 for one cycle.
  - Valid is therefore high for exactly TIMEOUT cycles before a drop.
  - The counter never wraps.
- TIMEOUT=0: no drop ever occurs; drop_o stays 0.
- Invariants:
  - out_valid_o is zero or one-hot, never multi-hot.
  - busy_o == |out_valid_o.
  - out_data_o holds its last value in IDLE (not zeroed).

Test Plan:
- Reset then addressed mode: in_dest_i=2, in_data_i=16'hBEEF, out_ready_i=4'b0100 -> out_valid_o=4'b0100 one cycle after accept; out_data_o=BEEF; IDLE the following cycle.
- Round-robin streaming: mode_rr_i=1, 6 consecutive words, all lanes ready -> out_valid_o sequence 0001,0010,0100,1000,0001,0010 at 1 word/cycle; rr_ptr_o ends at 2.
- Backpressure: addressed to lane 1 with out_ready_i=4'b1101 for 5 cycles, then 4'b0010 -> valid and data stable for all stalled cycles; in_ready_o=0 during the stall; in_ready_o=1 in the completing cycle.
- Timeout: TIMEOUT=4, lane 3 never ready -> out_valid_o=4'b1000 for exactly 4 cycles; drop_o pulses once; rr_ptr_o unchanged; next word accepted normally.
- Mode mix: round-robin accept (ptr 0->1), addressed accept to lane 3, round-robin accept -> lanes a, d, b; final rr_ptr_o=2.
- Mid-operation reset: rst_n_i low during a stalled HOLD -> next cycle out_valid_o=0, busy_o=0, rr_ptr_o=0, drop_o=0, in_ready_o=1.
